// File: rtl/frame_streamer.sv
// Frame buffer for face_detector: streams one stored frame in raster order, then captures the result.
// Latency: first pixel 2 cycles after det_start; stall=1 suppresses the next beat with no loss or repeat.
module frame_streamer #(
  parameter int IMG_WIDTH      = 64,
  parameter int IMG_HEIGHT     = 64,
  parameter int PIXEL_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int ADDR_W        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic                   go,
  input  logic                   stall,
  output logic                   busy,
  output logic                   det_start,
  output logic [PIXEL_WIDTH-1:0] det_pixel,
  output logic                   det_pixel_valid,
  input  logic                   det_face_detected,
  input  logic [7:0]             det_face_x,
  input  logic [7:0]             det_face_y,
  input  logic [7:0]             det_face_scale,
  input  logic                   det_done,
  output logic                   res_valid,
  output logic                   res_face,
  output logic [7:0]             res_x,
  output logic [7:0]             res_y,
  output logic [7:0]             res_scale,
  output logic                   res_timeout
);

  localparam int                NPIX      = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W:0]   NPIX_W    = (ADDR_W + 1)'(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int                TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TLAST     = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      pix_cnt;
  logic [TW-1:0]          wait_cnt;
  logic                   done_lat;
  logic                   pix_ok;
  logic [PIXEL_WIDTH-1:0] rd_q;
  logic [PIXEL_WIDTH-1:0] mem [NPIX];

  logic wr_ok;
  logic rd_en;

  assign wr_ok = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < NPIX_W);
  assign rd_en = (state == S_STREAM) && !stall;

  // Buffer kept out of the reset domain so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q <= mem[pix_cnt];
    end
  end

  // rd_q is unreset; pix_ok forces det_pixel to 0 until the first read after reset.
  assign det_pixel = pix_ok ? rd_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      det_start       <= 1'b0;
      det_pixel_valid <= 1'b0;
      pix_cnt         <= '0;
      wait_cnt        <= '0;
      done_lat        <= 1'b0;
      pix_ok          <= 1'b0;
      res_valid       <= 1'b0;
      res_face        <= 1'b0;
      res_x           <= '0;
      res_y           <= '0;
      res_scale       <= '0;
      res_timeout     <= 1'b0;
    end else begin
      det_start       <= 1'b0;
      det_pixel_valid <= 1'b0;
      res_valid       <= 1'b0;

      // An early finisher is remembered until the report is produced.
      if (det_done && (state inside {S_START, S_STREAM, S_WAIT_DONE})) begin
        done_lat <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_START;
            busy      <= 1'b1;
            det_start <= 1'b1;
          end
        end

        S_START: begin
          pix_cnt <= '0;
          state   <= S_STREAM;
        end

        S_STREAM: begin
          if (!stall) begin
            det_pixel_valid <= 1'b1;
            pix_ok          <= 1'b1;
            pix_cnt         <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_ADDR) begin
              wait_cnt <= '0;
              state    <= S_WAIT_DONE;
            end
          end
        end

        S_WAIT_DONE: begin
          // A done seen in the final timeout cycle still wins.
          if (done_lat || det_done) begin
            res_valid   <= 1'b1;
            res_face    <= det_face_detected;
            res_x       <= det_face_x;
            res_y       <= det_face_y;
            res_scale   <= det_face_scale;
            res_timeout <= 1'b0;
            state       <= S_REPORT;
          end else if (wait_cnt == TLAST) begin
            res_valid   <= 1'b1;
            res_face    <= 1'b0;
            res_x       <= '0;
            res_y       <= '0;
            res_scale   <= '0;
            res_timeout <= 1'b1;
            state       <= S_REPORT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_REPORT: begin
          done_lat <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_start_pulse : assert property (@(posedge clk) disable iff (!rst_n) det_start |=> !det_start);
  a_res_in_busy : assert property (@(posedge clk) disable iff (!rst_n) res_valid |-> busy);
  a_pix_in_busy : assert property (@(posedge clk) disable iff (!rst_n) det_pixel_valid |-> busy);

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: table of detection runs plus reset-mid-run sequence.
module tb_frame_streamer;

  localparam int NPIX   = 4096;
  localparam int BUDGET = NPIX + 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        go;
  logic        stall;
  logic        busy;
  logic        det_start;
  logic [7:0]  det_pixel;
  logic        det_pixel_valid;
  logic        det_face_detected;
  logic [7:0]  det_face_x;
  logic [7:0]  det_face_y;
  logic [7:0]  det_face_scale;
  logic        det_done;
  logic        res_valid;
  logic        res_face;
  logic [7:0]  res_x;
  logic [7:0]  res_y;
  logic [7:0]  res_scale;
  logic        res_timeout;

  frame_streamer #(
    .IMG_WIDTH(64), .IMG_HEIGHT(64), .PIXEL_WIDTH(8), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .stall(stall), .busy(busy),
    .det_start(det_start), .det_pixel(det_pixel), .det_pixel_valid(det_pixel_valid),
    .det_face_detected(det_face_detected), .det_face_x(det_face_x),
    .det_face_y(det_face_y), .det_face_scale(det_face_scale), .det_done(det_done),
    .res_valid(res_valid), .res_face(res_face), .res_x(res_x), .res_y(res_y),
    .res_scale(res_scale), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         stall_a;    // issued-count at which 3 stall cycles start (-1 none)
    int         stall_b;
    int         done_beat;  // pulse det_done while this beat is on det_pixel (-1 none)
    int         done_off;   // pulse det_done this many cycles after the last beat (-1 none)
    bit         poke;       // go + wr_en to address 5 mid-stream
    bit         ff;
    logic [7:0] fx, fy, fs;
    int         exp_lb;     // cycle of last beat, relative to det_start cycle
    int         rep_off;    // res_valid cycle relative to last beat
    bit         e_face, e_to;
    logic [7:0] ex, ey, es;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int c, issued, beats, sla, slb, lb, done_cyc, rep_exp, rep_cyc, first_beat;
    int valid_err, data_err, busy_err, start_err, idle_err;
    bit prev_issue, issue, got_rep;
    c = 0; issued = 0; beats = 0; lb = -1; done_cyc = -1; rep_exp = -2; rep_cyc = -1;
    first_beat = -1; valid_err = 0; data_err = 0; busy_err = 0; start_err = 0; idle_err = 0;
    prev_issue = 1'b0; got_rep = 1'b0;
    sla = (v.stall_a >= 0) ? 3 : 0;
    slb = (v.stall_b >= 0) ? 3 : 0;
    det_face_detected = v.ff; det_face_x = v.fx; det_face_y = v.fy; det_face_scale = v.fs;

    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk($sformatf("c%0d det_start", idx), 32'(det_start), 32'd1);
    chk($sformatf("c%0d busy at start", idx), 32'(busy), 32'd1);

    while (!got_rep && c < BUDGET) begin
      if (det_pixel_valid !== prev_issue) valid_err++;
      if (det_pixel_valid === 1'b1) begin
        if (det_pixel !== 8'(beats)) data_err++;
        if (beats == 0) first_beat = c;
        beats++;
      end
      if (busy !== 1'b1) busy_err++;
      if (c > 0 && det_start !== 1'b0) start_err++;
      if (res_valid === 1'b1) begin
        got_rep = 1'b1;
        rep_cyc = c;
      end else begin
        det_done = (c == done_cyc);
        issue = 1'b0;
        stall = 1'b0;
        if (c >= 1 && issued < NPIX) begin
          if (issued == v.stall_a && sla > 0) begin
            stall = 1'b1; sla--;
          end else if (issued == v.stall_b && slb > 0) begin
            stall = 1'b1; slb--;
          end else begin
            issue = 1'b1;
            if (issued == v.done_beat) done_cyc = c + 1;
            if (issued == NPIX - 1) begin
              lb = c + 1;
              if (v.done_off >= 0) done_cyc = lb + v.done_off;
              rep_exp = lb + v.rep_off;
            end
            issued++;
          end
        end
        if (v.poke && c == 500) begin
          go = 1'b1; wr_en = 1'b1; wr_addr = 12'd5; wr_data = 8'hAA;
        end else begin
          go = 1'b0; wr_en = 1'b0;
        end
        prev_issue = issue;
        @(negedge clk);
        c++;
      end
    end
    det_done = 1'b0; stall = 1'b0; go = 1'b0; wr_en = 1'b0;

    chk($sformatf("c%0d first beat cycle", idx), 32'(first_beat), 32'd2);
    chk($sformatf("c%0d last beat cycle", idx), 32'(lb), 32'(v.exp_lb));
    chk($sformatf("c%0d beat count", idx), 32'(beats), 32'(NPIX));
    chk($sformatf("c%0d pixel data errors", idx), 32'(data_err), 32'd0);
    chk($sformatf("c%0d valid pattern errors", idx), 32'(valid_err), 32'd0);
    chk($sformatf("c%0d busy drop errors", idx), 32'(busy_err), 32'd0);
    chk($sformatf("c%0d extra det_start", idx), 32'(start_err), 32'd0);
    chk($sformatf("c%0d res_valid cycle", idx), 32'(rep_cyc), 32'(v.exp_lb + v.rep_off));
    chk($sformatf("c%0d res_face", idx), 32'(res_face), 32'(v.e_face));
    chk($sformatf("c%0d res_x", idx), 32'(res_x), 32'(v.ex));
    chk($sformatf("c%0d res_y", idx), 32'(res_y), 32'(v.ey));
    chk($sformatf("c%0d res_scale", idx), 32'(res_scale), 32'(v.es));
    chk($sformatf("c%0d res_timeout", idx), 32'(res_timeout), 32'(v.e_to));

    @(negedge clk);
    chk($sformatf("c%0d busy after report", idx), 32'(busy), 32'd0);
    chk($sformatf("c%0d res_valid one cycle", idx), 32'(res_valid), 32'd0);
    chk($sformatf("c%0d res_x held", idx), 32'(res_x), 32'(v.ex));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || det_start !== 1'b0) idle_err++;
    end
    chk($sformatf("c%0d idle after run", idx), 32'(idle_err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, c, rst_err;

    //             stA  stB   dB    dOff pk ff  fx     fy     fs     lb    rep e_f e_t ex     ey     es
    vecs[0] = '{  -1,   -1,   -1,   20, 0, 1, 8'd17, 8'd9,  8'd2,  4097, 21, 1, 0, 8'd17, 8'd9,  8'd2};
    vecs[1] = '{ 100, 4095,   -1,   20, 0, 0, 8'd33, 8'd44, 8'd3,  4103, 21, 0, 0, 8'd33, 8'd44, 8'd3};
    vecs[2] = '{  -1,   -1,   -1,   -1, 0, 1, 8'd5,  8'd6,  8'd7,  4097, 50, 0, 1, 8'd0,  8'd0,  8'd0};
    vecs[3] = '{  -1,   -1,   -1,   49, 0, 1, 8'd200,8'd100,8'd4,  4097, 50, 1, 0, 8'd200,8'd100,8'd4};
    vecs[4] = '{  -1,   -1, 1000,   -1, 1, 1, 8'd1,  8'd2,  8'd3,  4097,  1, 1, 0, 8'd1,  8'd2,  8'd3};
    vecs[5] = '{  -1,   -1,   -1,   20, 0, 1, 8'd9,  8'd8,  8'd7,  4097, 21, 1, 0, 8'd9,  8'd8,  8'd7};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; stall = 1'b0;
    det_face_detected = 1'b0; det_face_x = '0; det_face_y = '0; det_face_scale = '0; det_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        32'({busy, det_start, det_pixel_valid, det_pixel, res_valid, res_face, res_timeout}), 32'd0);
    chk("reset result fields", 32'({res_x, res_y, res_scale}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < NPIX; a++) begin
      wr_en = 1'b1; wr_addr = 12'(a); wr_data = 8'(a);
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_case(i, vecs[i]);

    // Reset asserted while beat 2000 is on the bus.
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    beats = 0; c = 0; rst_err = 0;
    while (c < BUDGET && beats < 2001) begin
      if (det_pixel_valid === 1'b1) beats++;
      if (beats < 2001) begin
        @(negedge clk);
        c++;
      end
    end
    chk("mid-run beat reached", 32'(beats), 32'd2001);
    chk("mid-run pixel 2000", 32'(det_pixel), 32'd208);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs",
        32'({busy, det_start, det_pixel_valid, det_pixel, res_valid, res_face, res_timeout}), 32'd0);
    chk("async reset result fields", 32'({res_x, res_y, res_scale}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) rst_err++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) rst_err++;
    end
    chk("no report after reset", 32'(rst_err), 32'd0);
    run_case(6, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
Synthesizable pixel-stream source for face_detector. Holds one frame in an internal buffer loaded by a host write port. On request it pulses start, streams the frame in raster order with valid qualification, then waits for done and captures the detection result into a report register. It replaces the behavioural pixel feeder so the detector can run on hardware with a real frame source.

Parameters:
IMG_WIDTH, 64, pixels per row
IMG_HEIGHT, 64, rows per frame
PIXEL_WIDTH, 8, bits per pixel
TIMEOUT_CYCLES, 2000000, max cycles in WAIT_DONE before abort
ADDR_W, derived localparam clog2(IMG_WIDTH*IMG_HEIGHT) (12 at defaults), not overridable

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host frame-buffer write strobe
wr_addr  in  ADDR_W  write address, row-major y*IMG_WIDTH+x
wr_data  in  PIXEL_WIDTH  write pixel
go  in  1  request one detection run (sampled in IDLE only)
stall  in  1  hold the stream; no pixel issued while high
busy  out  1  high from accepted go until res_valid cycle inclusive
det_start  out  1  one-cycle start pulse to detector
det_pixel  out  PIXEL_WIDTH  pixel to detector
det_pixel_valid  out  1  det_pixel qualifier
det_face_detected  in  1  detector result flag
det_face_x  in  8  detector face x
det_face_y  in  8  detector face y
det_face_scale  in  8  detector scale
det_done  in  1  detector completion
res_valid  out  1  one-cycle pulse, result registers updated
res_face  out  1  captured face flag (0 on timeout)
res_x  out  8  captured x
res_y  out  8  captured y
res_scale  out  8  captured scale
res_timeout  out  1  1 if run aborted by timeout

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; counters 0; done-latch 0. Buffer contents undefined, not cleared.
- Buffer: IMG_WIDTH*IMG_HEIGHT x PIXEL_WIDTH, sync write, 1-cycle sync read. wr_en honoured only in IDLE; ignored while busy. Writes to wr_addr >= W*H are dropped.
- FSM: IDLE -> START -> STREAM -> WAIT_DONE -> REPORT -> IDLE.
- IDLE: go=1 -> START next cycle; busy rises in the same cycle as the START entry.
- START: det_start=1 for exactly this cycle; pixel counter cleared; -> STREAM.
- STREAM: each cycle with stall=0 issues read address = counter and increments it. The pixel appears on det_pixel with det_pixel_valid=1 exactly one cycle later. stall=1 issues nothing, so det_pixel_valid=0 in the following cycle. First valid pixel is 2 cycles after the det_start cycle when there is no stall. Exactly W*H valid beats per run, addresses 0..W*H-1 in order. After the last address issues, the next cycle carries the last valid beat and the FSM enters WAIT_DONE. det_pixel holds its last value when valid is 0.
- det_done latch: det_done high at any time from START onward sets a sticky latch. This covers a detector that finishes early. The latch clears on REPORT.
- WAIT_DONE: latch set (or det_done now) -> REPORT, capturing det_face_* that cycle. Timeout counter counts WAIT_DONE cycles. On reaching TIMEOUT_CYCLES -> REPORT with res_timeout=1 and res_face/x/y/scale=0.
- REPORT: res_valid=1 for one cycle with updated res_* fields; busy still 1; -> IDLE. res_* hold until the next REPORT.
- Simultaneous det_done and timeout in the same cycle: det_done wins, res_timeout=0.
- go while busy: ignored, not queued.
- Reset mid-run: immediate return to IDLE, all outputs 0, no res_valid.

Test Plan:
- Load ramp pixel=addr[7:0], go, stall=0 -> det_start at cycle T, 4096 consecutive valid beats from T+2, beat k = k mod 256, no gaps.
- Same frame, stall high for 3 cycles at beats 100 and 4095 -> still exactly 4096 beats in order, valid low 3 cycles at each point, no duplicate or skipped pixel.
- Detector model asserts done 20 cycles after the last beat with face=1, x=17, y=9, scale=2 -> one res_valid pulse, res_face=1, res_x=17, res_y=9, res_scale=2, res_timeout=0, busy falls the cycle after.
- TIMEOUT_CYCLES=50, done never asserted -> res_valid exactly 50 cycles after WAIT_DONE entry with res_timeout=1 and all result fields 0. Then a done pulse asserted in the same cycle as the timeout -> res_timeout=0.
- Done pulsed during STREAM at beat 1000 -> streaming completes all 4096 beats, then REPORT the cycle after WAIT_DONE entry. go and wr_en asserted mid-run -> no effect, buffer unchanged.
- rst_n low at beat 2000 -> all outputs 0 asynchronously, no res_valid. New go after release -> full clean 4096-beat run.
